// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the two-port SDRAM command arbiter.
package sdram_arb_pkg;

  localparam int ARB_ADDR_W  = 22;
  localparam int ARB_DATA_W  = 16;
  localparam int ARB_BE_W    = 2;
  localparam int ARB_MAX_OUT = 4;
  localparam int ARB_CNT_W   = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_e;

  // Requester id: 0 = manual switch path, 1 = self-test.
  typedef logic owner_t;

  // Round-robin pick between two requesters; meaningful only when at least one is eligible.
  function automatic owner_t rr_pick(input logic elig0, input logic elig1, input owner_t last);
    return elig1 & (~elig0 | ~last);
  endfunction

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Owner-tag FIFO: remembers which requester each outstanding read belongs to,
// so returned data is routed back in issue order.
module sdram_arb_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  owner_t                     push_data_i,
  input  logic                       pop_i,
  output owner_t                     head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  owner_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     cnt_q;
  logic            do_push;
  logic            do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so push is allowed when full if a pop accompanies it.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Tag storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-port round-robin arbiter in front of the SDRAM controller command port.
// One command is in flight on az_*; read data is steered back by an owner-tag FIFO.
// Optional grant statistics are built when ARB_STATS_EN is defined.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W  = ARB_ADDR_W,
  parameter int DATA_W  = ARB_DATA_W,
  parameter int BE_W    = ARB_BE_W,
  parameter int MAX_OUT = ARB_MAX_OUT,
  parameter int CNT_W   = ARB_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [BE_W-1:0]   r0_be_n,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [BE_W-1:0]   r1_be_n,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              az_cs,
  output logic              az_wr_n,
  output logic              az_rd_n,
  output logic [BE_W-1:0]   az_be_n,
  output logic [ADDR_W-1:0] az_addr,
  output logic [DATA_W-1:0] az_data,
  input  logic              za_wait,
  input  logic              za_valid,
  input  logic [DATA_W-1:0] za_data,
  output logic              rd_err,
  output logic [CNT_W-1:0]  stat_gnt0,
  output logic [CNT_W-1:0]  stat_gnt1
);

  localparam int FCW = $clog2(MAX_OUT) + 1;

  arb_state_e        state_q, state_d;
  owner_t            last_q, last_d;
  owner_t            owner_q, owner_d;
  logic              az_cs_q, az_cs_d;
  logic              az_wr_n_q, az_wr_n_d;
  logic              az_rd_n_q, az_rd_n_d;
  logic [BE_W-1:0]   az_be_n_q, az_be_n_d;
  logic [ADDR_W-1:0] az_addr_q, az_addr_d;
  logic [DATA_W-1:0] az_data_q, az_data_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              rd_err_q;

  logic              fifo_push;
  logic              fifo_pop;
  owner_t            fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FCW-1:0]    fifo_cnt;
  logic              read_room;
  logic              elig0, elig1;
  owner_t            gnt_owner;

  // Reads are only granted while a tag slot is free; writes never wait on the FIFO.
  assign read_room = (fifo_cnt < FCW'(MAX_OUT));
  assign elig0     = r0_req & (r0_we | read_room);
  assign elig1     = r1_req & (r1_we | read_room);
  assign gnt_owner = rr_pick(elig0, elig1, last_q);
  assign fifo_pop  = za_valid & ~fifo_empty;

  sdram_arb_tag_fifo #(
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i (owner_q),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_cnt)
  );

  // Grant/issue FSM next-state and command register loads.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    az_cs_d   = az_cs_q;
    az_wr_n_d = az_wr_n_q;
    az_rd_n_d = az_rd_n_q;
    az_be_n_d = az_be_n_q;
    az_addr_d = az_addr_q;
    az_data_d = az_data_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    fifo_push = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (elig0 | elig1) begin
          state_d = ST_ISSUE;
          owner_d = gnt_owner;
          last_d  = gnt_owner;
          az_cs_d = 1'b1;
          if (gnt_owner) begin
            ack1_d    = 1'b1;
            az_wr_n_d = ~r1_we;
            az_rd_n_d = r1_we;
            az_be_n_d = r1_be_n;
            az_addr_d = r1_addr;
            az_data_d = r1_wdata;
          end else begin
            ack0_d    = 1'b1;
            az_wr_n_d = ~r0_we;
            az_rd_n_d = r0_we;
            az_be_n_d = r0_be_n;
            az_addr_d = r0_addr;
            az_data_d = r0_wdata;
          end
        end
      end
      ST_ISSUE: begin
        // Fields stay frozen until the controller stops waiting.
        if (!za_wait) begin
          state_d   = ST_IDLE;
          az_cs_d   = 1'b0;
          az_wr_n_d = 1'b1;
          az_rd_n_d = 1'b1;
          fifo_push = ~az_rd_n_q & ~fifo_full;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and command-port registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      az_cs_q   <= 1'b0;
      az_wr_n_q <= 1'b1;
      az_rd_n_q <= 1'b1;
      az_be_n_q <= '0;
      az_addr_q <= '0;
      az_data_q <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      az_cs_q   <= az_cs_d;
      az_wr_n_q <= az_wr_n_d;
      az_rd_n_q <= az_rd_n_d;
      az_be_n_q <= az_be_n_d;
      az_addr_q <= az_addr_d;
      az_data_q <= az_data_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
    end
  end

  // Read return: route controller data to the owner at the FIFO head; orphan data flags rd_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rd_err_q  <= 1'b0;
    end else begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      if (za_valid) begin
        if (fifo_empty) begin
          rd_err_q <= 1'b1;
        end else if (fifo_head) begin
          rvalid1_q <= 1'b1;
          rdata1_q  <= za_data;
        end else begin
          rvalid0_q <= 1'b1;
          rdata0_q  <= za_data;
        end
      end
    end
  end

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] gnt0_cnt_q;
  logic [CNT_W-1:0] gnt1_cnt_q;

  // Saturating grant counters, bumped on the grant edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt0_cnt_q <= '0;
      gnt1_cnt_q <= '0;
    end else begin
      if (ack0_d && (gnt0_cnt_q != '1)) gnt0_cnt_q <= gnt0_cnt_q + CNT_W'(1);
      if (ack1_d && (gnt1_cnt_q != '1)) gnt1_cnt_q <= gnt1_cnt_q + CNT_W'(1);
    end
  end

  assign stat_gnt0 = gnt0_cnt_q;
  assign stat_gnt1 = gnt1_cnt_q;
`else
  assign stat_gnt0 = '0;
  assign stat_gnt1 = '0;
`endif

  assign r0_ack    = ack0_q;
  assign r1_ack    = ack1_q;
  assign r0_rvalid = rvalid0_q;
  assign r1_rvalid = rvalid1_q;
  assign r0_rdata  = rdata0_q;
  assign r1_rdata  = rdata1_q;
  assign az_cs     = az_cs_q;
  assign az_wr_n   = az_wr_n_q;
  assign az_rd_n   = az_rd_n_q;
  assign az_be_n   = az_be_n_q;
  assign az_addr   = az_addr_q;
  assign az_data   = az_data_q;
  assign rd_err    = rd_err_q;

endmodule
